axi_xbar_1x2: RTL and testbench
===============================

# axi_xbar_1x2

AXI-lite 1-master-to-2-slave address-decoding crossbar, placed downstream of the fetch/LSU arbiter output and in front of the memory (slave 0) and device (slave 1) ports. It routes each read and write transaction to the slave selected by its address and locks that route until the response completes. Read and write channels are independent and may be in flight concurrently.

## Interface
Parameters:
- S0_BASE, 32'h8000_0000, slave 0 (SRAM) match value
- S0_MASK, 32'hF800_0000, slave 0 address mask
- S1_BASE, 32'hA000_0000, slave 1 (device) match value
- S1_MASK, 32'hFFFF_0000, slave 1 address mask

Ports (addr 32, data 32, strb 4, resp 2):
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready  master read channels (in/in/out, out/out/out/in)
- m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready  master write channels
- s0_*  full AXI-lite master-side port set to slave 0 (same signal list, directions mirrored)
- s1_*  full AXI-lite master-side port set to slave 1

## Operation
- Decode: hit_k = ((addr & Sk_MASK) == Sk_BASE); slave 0 wins if both hit; neither = unmapped.
- Read FSM R_IDLE, R_ADDR, R_DATA, R_ERR:
  - R_IDLE: arvalid low -> stay. Mapped: rsel latched from m_araddr, m_arvalid forwarded this cycle, -> R_DATA on arready, else R_ADDR.
  - R_ADDR: forward araddr/arvalid to rsel until s_arready -> R_DATA.
  - R_DATA: s_rdata/rresp/rvalid to master, m_rready to rsel; on rvalid&rready -> R_IDLE.
  - R_ERR: m_rvalid=1, m_rresp=2'b11, m_rdata=0 until m_rready -> R_IDLE.
- Write FSM W_IDLE, W_BUSY, W_RESP, W_ERR:
  - Route decoded from m_awaddr only; wvalid not forwarded while awvalid low in W_IDLE.
  - W_IDLE with awvalid: wsel latched, aw and w forwarded in same cycle; flags aw_done/w_done set per handshake; both done -> W_RESP, else W_BUSY.
  - W_BUSY: forward only the not-yet-done channel(s); both done -> W_RESP.
  - W_RESP: bresp/bvalid from wsel, m_bready to wsel; on bvalid&bready -> W_IDLE, flags cleared.
  - W_ERR: see Configuration.
- Non-selected slave: all valid/ready outputs 0, addr/data/strb 0. Master-side outputs 0 when idle.
- New transaction on a channel accepted only in its IDLE state (one outstanding per channel).

## Timing
- Reset: both FSMs IDLE, flags clear, rsel/wsel=0; every valid/ready output 0, m_rresp/m_bresp 0.
- Zero added latency: address, data and response paths combinational through latched route; handshake in cycle N reaches slave in cycle N.
- m_arready/m_awready/m_wready never asserted when the corresponding master valid is low.
- Back-to-back: R_IDLE entered on the rvalid&rready edge; next arvalid accepted the following cycle (1-cycle bubble), same for writes.
- Simultaneous read and write to different or same slave: both forwarded same cycle; no inter-channel ordering imposed.
- rst_n low mid-transaction: all state dropped in one cycle; outputs to reset values next cycle.

## Configuration
- AXI_XBAR_DECERR_EN defined: unmapped read -> m_arready=1 in R_IDLE, -> R_ERR. Unmapped write -> xbar itself accepts aw and w (awready/wready=1 on valid), W_ERR once both done: m_bvalid=1, m_bresp=2'b11 until m_bready. No slave sees the transaction.
- Undefined: unmapped addresses route to slave 0 as a default slave; R_ERR/W_ERR unreachable and omitted.

## Test plan
- Read 0x8000_0010, s0 arready 1 cycle later, rdata 0xDEAD_BEEF resp 0 -> master gets 0xDEAD_BEEF OKAY; s1_arvalid never high.
- Write 0xA000_03F8 data 0x41 strb 4'b0001, aw and w same cycle, s1 bresp 0 after 3 cycles -> s1 sees both, m_bvalid OKAY; s0 untouched.
- Write with wvalid 2 cycles after awvalid, s1 awready immediate -> W_BUSY holds wsel=1, w delivered to s1, single bresp.
- Concurrent read 0x8000_0000 and write 0xA000_0000 same cycle -> both complete on their slaves independently.
- Read 0x0000_1000 with AXI_XBAR_DECERR_EN -> arready same cycle, rvalid next cycle rresp 2'b11 rdata 0, held until rready; without macro -> forwarded to s0.
- rst_n low while in R_DATA with rvalid pending -> next cycle all outputs 0, FSM R_IDLE, next read routes normally.

Source files
------------

// File: rtl/axi_xbar_1x2.sv
// AXI-lite 1-master to 2-slave crossbar with address decode and per-channel route locking.
// Optional AXI_XBAR_DECERR_EN: unmapped accesses get a DECERR from the xbar instead of defaulting to slave 0.
module axi_xbar_1x2 #(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hF800_0000,
   parameter logic [31:0] S1_BASE = 32'hA000_0000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] m_araddr,
   input  logic        m_arvalid,
   output logic        m_arready,
   output logic [31:0] m_rdata,
   output logic [1:0]  m_rresp,
   output logic        m_rvalid,
   input  logic        m_rready,
   input  logic [31:0] m_awaddr,
   input  logic        m_awvalid,
   output logic        m_awready,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wstrb,
   input  logic        m_wvalid,
   output logic        m_wready,
   output logic [1:0]  m_bresp,
   output logic        m_bvalid,
   input  logic        m_bready,
   output logic [31:0] s0_araddr,
   output logic        s0_arvalid,
   input  logic        s0_arready,
   input  logic [31:0] s0_rdata,
   input  logic [1:0]  s0_rresp,
   input  logic        s0_rvalid,
   output logic        s0_rready,
   output logic [31:0] s0_awaddr,
   output logic        s0_awvalid,
   input  logic        s0_awready,
   output logic [31:0] s0_wdata,
   output logic [3:0]  s0_wstrb,
   output logic        s0_wvalid,
   input  logic        s0_wready,
   input  logic [1:0]  s0_bresp,
   input  logic        s0_bvalid,
   output logic        s0_bready,
   output logic [31:0] s1_araddr,
   output logic        s1_arvalid,
   input  logic        s1_arready,
   input  logic [31:0] s1_rdata,
   input  logic [1:0]  s1_rresp,
   input  logic        s1_rvalid,
   output logic        s1_rready,
   output logic [31:0] s1_awaddr,
   output logic        s1_awvalid,
   input  logic        s1_awready,
   output logic [31:0] s1_wdata,
   output logic [3:0]  s1_wstrb,
   output logic        s1_wvalid,
   input  logic        s1_wready,
   input  logic [1:0]  s1_bresp,
   input  logic        s1_bvalid,
   output logic        s1_bready
);

`ifdef AXI_XBAR_DECERR_EN
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP, W_ERR} wr_state_t;
`else
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} wr_state_t;
`endif

   rd_state_t   r_rstate, w_rstate_nxt;
   wr_state_t   r_wstate, w_wstate_nxt, w_wdone_st;
   logic        r_rsel, w_rsel_nxt;
   logic        r_wsel, w_wsel_nxt;
   logic        r_aw_done, w_aw_done_nxt;
   logic        r_w_done, w_w_done_nxt;
   logic        w_ar_sel, w_aw_sel;
   logic        w_fwd_ar, w_ar_tgt, w_fwd_r;
   logic        w_fwd_aw, w_fwd_w, w_w_tgt, w_fwd_b;
   logic [1:0]  w_s_arready, w_s_rvalid, w_s_awready, w_s_wready, w_s_bvalid;
   logic [31:0] w_s_rdata [2];
   logic [1:0]  w_s_rresp [2];
   logic [1:0]  w_s_bresp [2];

   // Slave 0 wins on overlap and also absorbs unmapped addresses in the default build.
   assign w_ar_sel = ((m_araddr & S0_MASK) != S0_BASE) && ((m_araddr & S1_MASK) == S1_BASE);
   assign w_aw_sel = ((m_awaddr & S0_MASK) != S0_BASE) && ((m_awaddr & S1_MASK) == S1_BASE);

`ifdef AXI_XBAR_DECERR_EN
   logic w_ar_unmapped, w_aw_unmapped, r_werr, w_werr_nxt;
   assign w_ar_unmapped = ((m_araddr & S0_MASK) != S0_BASE) && ((m_araddr & S1_MASK) != S1_BASE);
   assign w_aw_unmapped = ((m_awaddr & S0_MASK) != S0_BASE) && ((m_awaddr & S1_MASK) != S1_BASE);
   assign w_wdone_st    = ((r_wstate == W_IDLE) ? w_aw_unmapped : r_werr) ? W_ERR : W_RESP;
`else
   assign w_wdone_st    = W_RESP;
`endif

   assign w_s_arready = {s1_arready, s0_arready};
   assign w_s_rvalid  = {s1_rvalid,  s0_rvalid};
   assign w_s_awready = {s1_awready, s0_awready};
   assign w_s_wready  = {s1_wready,  s0_wready};
   assign w_s_bvalid  = {s1_bvalid,  s0_bvalid};
   assign w_s_rdata[0] = s0_rdata;
   assign w_s_rdata[1] = s1_rdata;
   assign w_s_rresp[0] = s0_rresp;
   assign w_s_rresp[1] = s1_rresp;
   assign w_s_bresp[0] = s0_bresp;
   assign w_s_bresp[1] = s1_bresp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rstate  <= R_IDLE;
         r_rsel    <= 1'b0;
         r_wstate  <= W_IDLE;
         r_wsel    <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
`ifdef AXI_XBAR_DECERR_EN
         r_werr    <= 1'b0;
`endif
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_rsel    <= w_rsel_nxt;
         r_wstate  <= w_wstate_nxt;
         r_wsel    <= w_wsel_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
`ifdef AXI_XBAR_DECERR_EN
         r_werr    <= w_werr_nxt;
`endif
      end
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rsel_nxt   = r_rsel;
      w_fwd_ar     = 1'b0;
      w_ar_tgt     = r_rsel;
      w_fwd_r      = 1'b0;
      m_arready    = 1'b0;
      m_rvalid     = 1'b0;
      m_rdata      = '0;
      m_rresp      = 2'b00;
      case (r_rstate)
         R_IDLE: if (m_arvalid) begin
`ifdef AXI_XBAR_DECERR_EN
            if (w_ar_unmapped) begin
               m_arready    = 1'b1;
               w_rstate_nxt = R_ERR;
            end else
`endif
            begin
               w_rsel_nxt   = w_ar_sel;
               w_ar_tgt     = w_ar_sel;
               w_fwd_ar     = 1'b1;
               m_arready    = w_s_arready[w_ar_sel];
               w_rstate_nxt = m_arready ? R_DATA : R_ADDR;
            end
         end
         R_ADDR: begin
            w_fwd_ar  = m_arvalid;
            m_arready = m_arvalid && w_s_arready[r_rsel];
            if (m_arready) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            m_rvalid = w_s_rvalid[r_rsel];
            m_rdata  = w_s_rdata[r_rsel];
            m_rresp  = w_s_rresp[r_rsel];
            w_fwd_r  = m_rready;
            if (m_rvalid && m_rready) w_rstate_nxt = R_IDLE;
         end
`ifdef AXI_XBAR_DECERR_EN
         R_ERR: begin
            m_rvalid = 1'b1;
            m_rresp  = 2'b11;
            if (m_rready) w_rstate_nxt = R_IDLE;
         end
`endif
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_wstate_nxt  = r_wstate;
      w_wsel_nxt    = r_wsel;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
`ifdef AXI_XBAR_DECERR_EN
      w_werr_nxt    = r_werr;
`endif
      w_fwd_aw      = 1'b0;
      w_fwd_w       = 1'b0;
      w_w_tgt       = r_wsel;
      w_fwd_b       = 1'b0;
      m_awready     = 1'b0;
      m_wready      = 1'b0;
      m_bvalid      = 1'b0;
      m_bresp       = 2'b00;
      case (r_wstate)
         W_IDLE: if (m_awvalid) begin
            w_wsel_nxt = w_aw_sel;
            w_w_tgt    = w_aw_sel;
`ifdef AXI_XBAR_DECERR_EN
            w_werr_nxt = w_aw_unmapped;
            if (w_aw_unmapped) begin
               m_awready = 1'b1;
               m_wready  = m_wvalid;
            end else
`endif
            begin
               w_fwd_aw  = 1'b1;
               w_fwd_w   = m_wvalid;
               m_awready = w_s_awready[w_aw_sel];
               m_wready  = m_wvalid && w_s_wready[w_aw_sel];
            end
            w_aw_done_nxt = m_awready;
            w_w_done_nxt  = m_wready;
            w_wstate_nxt  = (m_awready && m_wready) ? w_wdone_st : W_BUSY;
         end
         W_BUSY: begin
`ifdef AXI_XBAR_DECERR_EN
            if (r_werr) begin
               m_awready = m_awvalid && !r_aw_done;
               m_wready  = m_wvalid && !r_w_done;
            end else
`endif
            begin
               w_fwd_aw  = m_awvalid && !r_aw_done;
               w_fwd_w   = m_wvalid && !r_w_done;
               m_awready = w_fwd_aw && w_s_awready[r_wsel];
               m_wready  = w_fwd_w && w_s_wready[r_wsel];
            end
            w_aw_done_nxt = r_aw_done || m_awready;
            w_w_done_nxt  = r_w_done || m_wready;
            if (w_aw_done_nxt && w_w_done_nxt) w_wstate_nxt = w_wdone_st;
         end
         W_RESP: begin
            m_bvalid = w_s_bvalid[r_wsel];
            m_bresp  = w_s_bresp[r_wsel];
            w_fwd_b  = m_bready;
            if (m_bvalid && m_bready) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
`ifdef AXI_XBAR_DECERR_EN
         W_ERR: begin
            m_bvalid = 1'b1;
            m_bresp  = 2'b11;
            if (m_bready) begin
               w_wstate_nxt  = W_IDLE;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_werr_nxt    = 1'b0;
            end
         end
`endif
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   assign s0_arvalid = w_fwd_ar && !w_ar_tgt;
   assign s1_arvalid = w_fwd_ar && w_ar_tgt;
   assign s0_araddr  = s0_arvalid ? m_araddr : '0;
   assign s1_araddr  = s1_arvalid ? m_araddr : '0;
   assign s0_rready  = w_fwd_r && !r_rsel;
   assign s1_rready  = w_fwd_r && r_rsel;

   assign s0_awvalid = w_fwd_aw && !w_w_tgt;
   assign s1_awvalid = w_fwd_aw && w_w_tgt;
   assign s0_awaddr  = s0_awvalid ? m_awaddr : '0;
   assign s1_awaddr  = s1_awvalid ? m_awaddr : '0;
   assign s0_wvalid  = w_fwd_w && !w_w_tgt;
   assign s1_wvalid  = w_fwd_w && w_w_tgt;
   assign s0_wdata   = s0_wvalid ? m_wdata : '0;
   assign s1_wdata   = s1_wvalid ? m_wdata : '0;
   assign s0_wstrb   = s0_wvalid ? m_wstrb : '0;
   assign s1_wstrb   = s1_wvalid ? m_wstrb : '0;
   assign s0_bready  = w_fwd_b && !r_wsel;
   assign s1_bready  = w_fwd_b && r_wsel;

endmodule

// File: tb/tb_axi_xbar_1x2.sv
// Directed bench for axi_xbar_1x2: table of routed reads plus hand-written multi-cycle sequences.
module tb_axi_xbar_1x2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] m_araddr = '0;
   logic        m_arvalid = 1'b0, m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid, m_rready = 1'b0;
   logic [31:0] m_awaddr = '0;
   logic        m_awvalid = 1'b0, m_awready;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic        m_wvalid = 1'b0, m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready = 1'b0;
   logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
   logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready, s0_awvalid, s1_awvalid;
   logic        s0_wvalid, s1_wvalid, s0_bready, s1_bready;
   logic [3:0]  s0_wstrb, s1_wstrb;
   logic        s0_arready = 1'b0, s1_arready = 1'b0, s0_rvalid = 1'b0, s1_rvalid = 1'b0;
   logic        s0_awready = 1'b0, s1_awready = 1'b0, s0_wready = 1'b0, s1_wready = 1'b0;
   logic        s0_bvalid = 1'b0, s1_bvalid = 1'b0;
   logic [31:0] s0_rdata = '0, s1_rdata = '0;
   logic [1:0]  s0_rresp = '0, s1_rresp = '0, s0_bresp = '0, s1_bresp = '0;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        sel;
   } rd_vec_t;
   rd_vec_t vecs [4];

   axi_xbar_1x2 dut (
      .clk(clk), .rst_n(rst_n),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
      .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
      .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
      .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
      .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
      .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clear_slaves();
      s0_arready = 0; s1_arready = 0; s0_rvalid = 0; s1_rvalid = 0;
      s0_awready = 0; s1_awready = 0; s0_wready = 0; s1_wready = 0;
      s0_bvalid = 0;  s1_bvalid = 0;  s0_rdata = '0; s1_rdata = '0;
      s0_rresp = '0;  s1_rresp = '0;  s0_bresp = '0; s1_bresp = '0;
   endtask

   initial begin
      vecs[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1'b0};
      vecs[1] = '{32'hA000_0004, 32'h1234_5678, 2'b00, 1'b1};
      vecs[2] = '{32'h87FF_FFFC, 32'h0BAD_F00D, 2'b10, 1'b0};
      vecs[3] = '{32'hA000_FFFC, 32'hCAFE_0001, 2'b01, 1'b1};

      repeat (3) tick();
      rst_n = 1;
      // Reset state, with slave readies high to catch unqualified ready paths
      s0_arready = 1; s0_awready = 1; s0_wready = 1; s0_rvalid = 1; s0_bvalid = 1;
      #1;
      chk("rst_m_arready", m_arready, 0);
      chk("rst_m_awready", m_awready, 0);
      chk("rst_m_wready", m_wready, 0);
      chk("rst_m_rvalid", m_rvalid, 0);
      chk("rst_m_bvalid", m_bvalid, 0);
      chk("rst_s0_arvalid", s0_arvalid, 0);
      clear_slaves();

      for (int i = 0; i < 4; i++) begin
         m_araddr = vecs[i].addr; m_arvalid = 1;
         s0_arready = !vecs[i].sel; s1_arready = vecs[i].sel;
         #1;
         chk("tbl_arvalid_sel", vecs[i].sel ? s1_arvalid : s0_arvalid, 1);
         chk("tbl_arvalid_other", vecs[i].sel ? s0_arvalid : s1_arvalid, 0);
         chk("tbl_araddr", vecs[i].sel ? s1_araddr : s0_araddr, vecs[i].addr);
         chk("tbl_arready", m_arready, 1);
         tick();
         m_arvalid = 0; m_araddr = '0; clear_slaves();
         s0_rvalid = 1; s1_rvalid = 1; m_rready = 1;
         s0_rdata = vecs[i].sel ? 32'hFFFF_FFFF : vecs[i].rdata;
         s1_rdata = vecs[i].sel ? vecs[i].rdata : 32'hFFFF_FFFF;
         s0_rresp = vecs[i].sel ? 2'b11 : vecs[i].rresp;
         s1_rresp = vecs[i].sel ? vecs[i].rresp : 2'b11;
         #1;
         chk("tbl_rvalid", m_rvalid, 1);
         chk("tbl_rdata", m_rdata, vecs[i].rdata);
         chk("tbl_rresp", m_rresp, vecs[i].rresp);
         chk("tbl_rready_sel", vecs[i].sel ? s1_rready : s0_rready, 1);
         chk("tbl_rready_other", vecs[i].sel ? s0_rready : s1_rready, 0);
         tick();
         clear_slaves(); m_rready = 0;
         #1;
         chk("tbl_idle_rvalid", m_rvalid, 0);
      end

      // Read to s0 with arready one cycle late
      m_araddr = 32'h8000_0010; m_arvalid = 1; #1;
      chk("late_s0_arvalid", s0_arvalid, 1);
      chk("late_m_arready0", m_arready, 0);
      chk("late_s1_arvalid", s1_arvalid, 0);
      tick();
      s0_arready = 1; #1;
      chk("late_m_arready1", m_arready, 1);
      chk("late_s0_arvalid2", s0_arvalid, 1);
      tick();
      m_arvalid = 0; s0_arready = 0; s0_rvalid = 1; s0_rdata = 32'hDEAD_BEEF; m_rready = 1; #1;
      chk("late_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("late_s1_arvalid3", s1_arvalid, 0);
      tick();
      clear_slaves(); m_rready = 0;

      // Write to s1, aw and w together, bresp after three cycles
      m_awaddr = 32'hA000_03F8; m_awvalid = 1; m_wdata = 32'h41; m_wstrb = 4'b0001; m_wvalid = 1;
      s1_awready = 1; s1_wready = 1; #1;
      chk("wr_s1_awvalid", s1_awvalid, 1);
      chk("wr_s1_awaddr", s1_awaddr, 32'hA000_03F8);
      chk("wr_s1_wvalid", s1_wvalid, 1);
      chk("wr_s1_wdata", s1_wdata, 32'h41);
      chk("wr_s1_wstrb", s1_wstrb, 4'b0001);
      chk("wr_s0_awvalid", s0_awvalid, 0);
      chk("wr_s0_wvalid", s0_wvalid, 0);
      chk("wr_m_awready", m_awready, 1);
      chk("wr_m_wready", m_wready, 1);
      tick();
      m_awvalid = 0; m_wvalid = 0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
      clear_slaves(); m_bready = 1;
      repeat (2) begin
         #1; chk("wr_bvalid_wait", m_bvalid, 0);
         tick();
      end
      s1_bvalid = 1; s0_bvalid = 1; s0_bresp = 2'b11; #1;
      chk("wr_m_bvalid", m_bvalid, 1);
      chk("wr_m_bresp", m_bresp, 0);
      chk("wr_s1_bready", s1_bready, 1);
      chk("wr_s0_bready", s0_bready, 0);
      tick();
      clear_slaves(); m_bready = 0;

      // Write with wvalid two cycles after awvalid
      m_awaddr = 32'hA000_0100; m_awvalid = 1; s1_awready = 1; s1_wready = 1; #1;
      chk("split_m_awready", m_awready, 1);
      chk("split_m_wready0", m_wready, 0);
      chk("split_s1_wvalid0", s1_wvalid, 0);
      tick();
      m_awvalid = 0; m_awaddr = '0; #1;
      chk("split_s1_awvalid_busy", s1_awvalid, 0);
      chk("split_m_awready_busy", m_awready, 0);
      tick();
      m_wvalid = 1; m_wdata = 32'h5A5A_0003; m_wstrb = 4'b1111; #1;
      chk("split_s1_wvalid", s1_wvalid, 1);
      chk("split_s1_wdata", s1_wdata, 32'h5A5A_0003);
      chk("split_s0_wvalid", s0_wvalid, 0);
      chk("split_m_wready", m_wready, 1);
      tick();
      m_wvalid = 0; m_wdata = '0; m_wstrb = '0; clear_slaves();
      s1_bvalid = 1; m_bready = 1; #1;
      chk("split_m_bvalid", m_bvalid, 1);
      tick();
      #1;
      chk("split_single_bresp", m_bvalid, 0);
      clear_slaves(); m_bready = 0;

      // Concurrent read to s0 and write to s1
      m_araddr = 32'h8000_0000; m_arvalid = 1; s0_arready = 1;
      m_awaddr = 32'hA000_0000; m_awvalid = 1; m_wvalid = 1; m_wdata = 32'h77; m_wstrb = 4'b1100;
      s1_awready = 1; s1_wready = 1; #1;
      chk("cc_s0_arvalid", s0_arvalid, 1);
      chk("cc_s1_awvalid", s1_awvalid, 1);
      chk("cc_s1_wvalid", s1_wvalid, 1);
      chk("cc_s1_arvalid", s1_arvalid, 0);
      chk("cc_s0_awvalid", s0_awvalid, 0);
      tick();
      m_arvalid = 0; m_awvalid = 0; m_wvalid = 0; clear_slaves();
      s0_rvalid = 1; s0_rdata = 32'h55; s1_bvalid = 1; s1_bresp = 2'b10; m_rready = 1; m_bready = 1; #1;
      chk("cc_m_rdata", m_rdata, 32'h55);
      chk("cc_m_bvalid", m_bvalid, 1);
      chk("cc_m_bresp", m_bresp, 2'b10);
      tick();
      clear_slaves(); m_rready = 0; m_bready = 0;

      // Unmapped read
      m_araddr = 32'h0000_1000; m_arvalid = 1;
`ifdef AXI_XBAR_DECERR_EN
      #1;
      chk("um_m_arready", m_arready, 1);
      chk("um_s0_arvalid", s0_arvalid, 0);
      chk("um_s1_arvalid", s1_arvalid, 0);
      tick();
      m_arvalid = 0; #1;
      chk("um_rvalid", m_rvalid, 1);
      chk("um_rresp", m_rresp, 2'b11);
      chk("um_rdata", m_rdata, 0);
      tick();
      chk("um_rvalid_hold", m_rvalid, 1);
      m_rready = 1;
      tick();
      m_rready = 0; #1;
      chk("um_idle", m_rvalid, 0);
`else
      s0_arready = 1; #1;
      chk("um_s0_arvalid", s0_arvalid, 1);
      chk("um_s1_arvalid", s1_arvalid, 0);
      chk("um_m_arready", m_arready, 1);
      tick();
      m_arvalid = 0; clear_slaves(); s0_rvalid = 1; s0_rdata = 32'h7; m_rready = 1; #1;
      chk("um_rdata", m_rdata, 32'h7);
      tick();
      clear_slaves(); m_rready = 0;
`endif

      // Reset while in R_DATA with rvalid pending
      m_araddr = 32'hA000_0040; m_arvalid = 1; s1_arready = 1;
      tick();
      m_arvalid = 0; s1_arready = 0; s1_rvalid = 1; s1_rdata = 32'hABCD; #1;
      chk("rst_pre_rvalid", m_rvalid, 1);
      rst_n = 0; m_rready = 1;
      tick();
      chk("rst_mid_rvalid", m_rvalid, 0);
      chk("rst_mid_s1_rready", s1_rready, 0);
      chk("rst_mid_rdata", m_rdata, 0);
      rst_n = 1; m_rready = 0; clear_slaves();
      m_araddr = 32'hA000_0008; m_arvalid = 1; s1_arready = 1; #1;
      chk("rst_after_s1_arvalid", s1_arvalid, 1);
      chk("rst_after_m_arready", m_arready, 1);
      tick();
      m_arvalid = 0; clear_slaves();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
